uart_tx_feeder: RTL

Byte buffer and handshake front end that sits directly upstream of the UART TX core. It accepts bytes from the system side into a small FIFO and presents them one at a time on the parallel-data/data-valid inputs of the TX framer. Each byte is held stable for the full frame, and the next byte is launched only after the TX core's Busy falls. A retry path re-issues the data-valid pulse if the TX core fails to acknowledge with Busy.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 104 ++++++++++
 rtl/uart_tx_feeder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit front end.
//   - feeder_state_e : encoding of the feeder FSM states
//   - DEFAULT_DATA_WIDTH : default byte width, matched to the TX serializer
//   - count_width()  : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_ACK  = 2'b01,
        WAIT_DONE = 2'b10
    } feeder_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // An occupancy count must represent the full value "depth", which needs
    // one bit more than a pointer into a power-of-two buffer.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Circular byte buffer with a separate occupancy counter.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset (pointers/count/flags)
//   push_i      in   enqueue request; accepted only when not full
//   push_data_i in   data to enqueue
//   pop_i       in   dequeue request; honoured only when not empty
//   pop_data_o  out  entry at the read pointer (combinational read)
//   full_o      out  count == DEPTH
//   empty_o     out  count == 0
//   count_o     out  occupancy 0..DEPTH
//   overflow_o  out  registered one-cycle pulse for a push rejected as full
// ---------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         pop_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [count_width(DEPTH)-1:0] count_o,
    output logic                          overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    // Storage is not reset; only the bookkeeping around it is.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Fullness is judged on the current count, so a push into a full buffer
    // is refused even if a pop frees a slot on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push_i && full_o;

        // Pointers are exactly log2(DEPTH) wide and wrap on overflow.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Read is combinational; the consumer registers the value when it pops,
    // which keeps launch latency at a single edge after the pop decision.
    assign pop_data_o = mem[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Buffers bytes from the system side and hands them one at a time to the
// UART TX framer. Each byte is held on P_DATA for the whole frame; the next
// byte is launched only once the TX core drops Busy. If the core does not
// raise Busy in response to a launch, the Data_Valid pulse is re-issued.
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-low reset
//   WR_DATA     in   byte to enqueue
//   WR_VALID    in   enqueue request
//   WR_READY    out  buffer not full
//   Busy        in   TX core busy (Starting through Ending)
//   P_DATA      out  byte being transmitted (registered)
//   Data_Valid  out  one-cycle launch pulse to the TX FSM (registered)
//   FIFO_COUNT  out  buffer occupancy
//   OVERFLOW    out  one-cycle pulse for a write refused while full
//   RETRY_ERR   out  sticky flag, set on the first re-issued launch
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         WR_DATA,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    input  logic                          Busy,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          Data_Valid,
    output logic [count_width(DEPTH)-1:0] FIFO_COUNT,
    output logic                          OVERFLOW,
    output logic                          RETRY_ERR
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    feeder_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  retry_q, retry_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (WR_VALID),
        .push_data_i (WR_DATA),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (FIFO_COUNT),
        .overflow_o  (OVERFLOW)
    );

    assign WR_READY = !fifo_full;

    always_comb begin
        state_d  = state_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                // Busy high here means the TX core is owned by someone else;
                // hold off until it is free.
                if (!fifo_empty && !Busy) begin
                    fifo_pop = 1'b1;
                    p_data_d = fifo_data;
                    dv_d     = 1'b1;
                    tmo_d    = '0;
                    state_d  = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (Busy) begin
                    tmo_d   = '0;
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT)) begin
                    // No acknowledge: re-launch the same byte without popping.
                    // The counter restart guarantees Data_Valid never repeats
                    // on consecutive cycles.
                    dv_d    = 1'b1;
                    tmo_d   = '0;
                    retry_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            WAIT_DONE: begin
                if (!Busy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Asynchronous reset also clears Data_Valid immediately, so a reset in the
    // middle of a launch cannot leave a pulse on the TX core input.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            p_data_q <= '0;
            dv_q     <= 1'b0;
            retry_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign RETRY_ERR  = retry_q;

endmodule
